// File: rtl/zeroriscy_multdiv_seq_if.sv
// zeroriscy_multdiv_seq_if: request/result bus between decoder/writeback and the multdiv sequencer
interface zeroriscy_multdiv_seq_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        kill_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  modport master (output start_i, op_i, operand_a_i, operand_b_i, kill_i, input ready_o, valid_o, result_o);
  modport slave (input start_i, op_i, operand_a_i, operand_b_i, kill_i, output ready_o, valid_o, result_o);
endinterface

// File: rtl/zeroriscy_multdiv_seq.sv
// zeroriscy_multdiv_seq: iterative MUL/MULHU/DIVU/REMU sharing the ALU 33-bit adder
module zeroriscy_multdiv_seq (
  input  logic                          clk,
  input  logic                          rst_n,
  zeroriscy_multdiv_seq_if.slave        bus,
  input  logic [33:0]                   alu_adder_ext_i,
  output logic [32:0]                   alu_operand_a_o,
  output logic [32:0]                   alu_operand_b_o,
  output logic                          alu_en_o
);
  localparam logic [2:0] IDLE = 3'd0, NEG = 3'd1, MUL = 3'd2, DIV = 3'd3, FINISH = 3'd4;
  logic [2:0]  state;
  logic [4:0]  count;
  logic        sel_hi;
  logic [31:0] acc, lo, mcand, q, r, res;
  logic [32:0] ndiv, sum, partial;
  logic [31:0] acc_n, lo_n, q_n, r_n;
  logic        carry, last;
  always_comb begin
    sum = alu_adder_ext_i[32:0];
    carry = alu_adder_ext_i[33];
    partial = {r, q[31]};
    last = count == 5'd31;
    acc_n = sum[32:1];
    lo_n = {sum[0], lo[31:1]};
    r_n = carry ? sum[31:0] : partial[31:0];
    q_n = {q[30:0], carry};
    alu_en_o = state == NEG || state == MUL || state == DIV;
    alu_operand_a_o = state == MUL ? {1'b0, acc} : state == NEG ? ~{1'b0, mcand} : state == DIV ? partial : '0;
    alu_operand_b_o = state == MUL ? (lo[0] ? {1'b0, mcand} : '0) : state == NEG ? 33'd1 : state == DIV ? ndiv : '0;
  end
  assign bus.ready_o = state == IDLE;
  assign bus.valid_o = state == FINISH;
  assign bus.result_o = res;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      sel_hi <= 1'b0;
      acc <= '0;
      lo <= '0;
      mcand <= '0;
      q <= '0;
      r <= '0;
      ndiv <= '0;
      res <= '0;
    end else if (bus.kill_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          sel_hi <= bus.op_i[0];
          mcand <= bus.operand_b_i;
          count <= '0;
          if (!bus.op_i[1]) begin
            acc <= '0;
            lo <= bus.operand_a_i;
            state <= MUL;
          end else if (bus.operand_b_i == '0) begin
            res <= bus.op_i[0] ? bus.operand_a_i : '1;
            state <= FINISH;
          end else begin
            q <= bus.operand_a_i;
            r <= '0;
            state <= NEG;
          end
        end
        NEG: begin
          ndiv <= sum;
          count <= '0;
          state <= DIV;
        end
        MUL: begin
          acc <= acc_n;
          lo <= lo_n;
          count <= count + 5'd1;
          if (last) begin
            res <= sel_hi ? acc_n : lo_n;
            state <= FINISH;
          end
        end
        DIV: begin
          r <= r_n;
          q <= q_n;
          count <= count + 5'd1;
          if (last) begin
            res <= sel_hi ? r_n : q_n;
            state <= FINISH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zeroriscy_multdiv_seq.sv
// tb_zeroriscy_multdiv_seq: directed vectors with a queue scoreboard and an independent result monitor
module tb_zeroriscy_multdiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [32:0] alu_a, alu_b;
  logic [33:0] alu_sum;
  logic        alu_en;
  int          checks = 0, errors = 0, ncyc = 0;
  typedef struct {logic [31:0] res; int cyc; int id;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  zeroriscy_multdiv_seq_if bus();
  zeroriscy_multdiv_seq dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .alu_adder_ext_i(alu_sum), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b), .alu_en_o(alu_en)
  );
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // Monitor: every valid pulse must match the oldest outstanding expectation, value and cycle.
  always @(negedge clk) if (rst_n && bus.valid_o) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_valid: got result %0h at cycle %0d, expected no valid", bus.result_o, ncyc);
    end else begin
      mon_e = sb.pop_front();
      chk($sformatf("result_%0d", mon_e.id), bus.result_o, mon_e.res);
      chk($sformatf("valid_cycle_%0d", mon_e.id), ncyc, mon_e.cyc);
    end
  end
  task automatic run(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input int lat, input int en_exp);
    int acc, en, k;
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    acc = ncyc;
    sb.push_back('{res, acc + lat, id});
    @(negedge clk);
    bus.start_i = 1'b0;
    en = 0;
    k = 0;
    while (!bus.ready_o && k < 100) begin
      en += int'(alu_en);
      @(negedge clk);
      k++;
    end
    chk($sformatf("ready_cycle_%0d", id), ncyc, acc + lat + 1);
    chk($sformatf("alu_en_cycles_%0d", id), en, en_exp);
    chk($sformatf("result_held_%0d", id), bus.result_o, res);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, k;
    bus.start_i = 1'b0;
    bus.op_i = 2'b00;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    bus.kill_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(1, 2'b00, 32'd7, 32'd6, 32'd42, 33, 32);
    run(2, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32);
    run(3, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32);
    run(4, 2'b10, 32'd100, 32'd7, 32'd14, 34, 33);
    run(5, 2'b11, 32'd100, 32'd7, 32'd2, 34, 33);
    run(6, 2'b10, 32'h80000000, 32'd1, 32'h80000000, 34, 33);
    run(7, 2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    run(8, 2'b11, 32'd5, 32'd0, 32'd5, 1, 0);
    run(9, 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 34, 33);
    run(10, 2'b10, 32'd3, 32'd5, 32'd0, 34, 33);
    run(11, 2'b01, 32'h12345678, 32'h100, 32'h12, 33, 32);
    // Kill a MUL at cycle 10: no pulse, result untouched, idle at cycle 11.
    bus.start_i = 1'b1;
    bus.op_i = 2'b00;
    bus.operand_a_i = 32'd3;
    bus.operand_b_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill_busy", bus.ready_o, 0);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("kill_ready", bus.ready_o, 1);
    chk("kill_valid", bus.valid_o, 0);
    chk("kill_result", bus.result_o, 32'h12);
    run(12, 2'b10, 32'd9, 32'd3, 32'd3, 34, 33);
    // Reset at cycle 20 of a DIVU.
    bus.start_i = 1'b1;
    bus.op_i = 2'b10;
    bus.operand_a_i = 32'd1000;
    bus.operand_b_i = 32'd9;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_alu_en", alu_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.ready_o, 1);
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_alu_en", alu_en, 0);
    chk("mid_rst_result", bus.result_o, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // start held and operands changed while busy: exactly one result.
    bus.start_i = 1'b1;
    bus.op_i = 2'b00;
    bus.operand_a_i = 32'h12345678;
    bus.operand_b_i = 32'h10;
    acc = ncyc;
    sb.push_back('{32'h23456780, acc + 33, 13});
    @(negedge clk);
    bus.op_i = 2'b11;
    bus.operand_a_i = 32'hDEADBEEF;
    bus.operand_b_i = 32'd0;
    k = 0;
    while (!bus.valid_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    bus.start_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_start_result", bus.result_o, 32'h23456780);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
